// File: rtl/sensor_andar_cabine.sv
// Plant-side model of the elevator cabin: integrates motor commands into a tick
// position and reports floor level, alignment, end-of-travel limits and a sticky fault.
module sensor_andar_cabine #(
    parameter int N_ANDARES       = 5,
    parameter int TICKS_POR_ANDAR = 4,
    parameter int DIVISOR         = 2,
    parameter int ANDAR_INICIAL   = 0,
    parameter int POS_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             motor_liga,
    input  logic             motor_direcao,
    output logic [2:0]       andar_atual,
    output logic [POS_W-1:0] posicao,
    output logic             no_nivel,
    output logic             em_movimento,
    output logic             fim_curso_inf,
    output logic             fim_curso_sup,
    output logic             falha
);

    localparam int PMAX   = (N_ANDARES - 1) * TICKS_POR_ANDAR;
    localparam int PRE_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int FRAC_W = $clog2(TICKS_POR_ANDAR);

    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(PMAX);
    localparam logic [POS_W-1:0]  POS_INI   = POS_W'(ANDAR_INICIAL * TICKS_POR_ANDAR);
    localparam logic [PRE_W-1:0]  PRE_ULT   = PRE_W'(DIVISOR - 1);
    localparam logic [FRAC_W-1:0] FRAC_ULT  = FRAC_W'(TICKS_POR_ANDAR - 1);
    localparam logic [2:0]        ANDAR_INI = 3'(ANDAR_INICIAL);

    typedef enum logic [1:0] {
        PASSO_NENHUM,
        PASSO_SOBE,
        PASSO_DESCE,
        PASSO_BLOQUEADO
    } passo_t;

    // Position is also kept as (floor below, ticks above it) so level detection
    // never needs a divider for non-power-of-two TICKS_POR_ANDAR.
    logic [PRE_W-1:0]  prescaler, prescaler_prox;
    logic [FRAC_W-1:0] fracao, fracao_prox;
    logic [2:0]        andar_base, andar_base_prox;
    logic [POS_W-1:0]  posicao_prox;
    logic [2:0]        andar_prox;
    logic              em_movimento_prox;
    logic              oportunidade;
    passo_t            passo;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        oportunidade      = motor_liga && (prescaler == PRE_ULT);
        passo             = PASSO_NENHUM;
        posicao_prox      = posicao;
        fracao_prox       = fracao;
        andar_base_prox   = andar_base;
        em_movimento_prox = em_movimento;
        prescaler_prox    = '0;

        if (motor_liga && !oportunidade) begin
            prescaler_prox = prescaler + PRE_W'(1);
        end

        // The registered limit flags are coherent with posicao, so they gate saturation.
        if (oportunidade) begin
            if (motor_direcao) begin
                passo = fim_curso_sup ? PASSO_BLOQUEADO : PASSO_SOBE;
            end else begin
                passo = fim_curso_inf ? PASSO_BLOQUEADO : PASSO_DESCE;
            end
        end

        case (passo)
            PASSO_SOBE: begin
                posicao_prox = posicao + POS_W'(1);
                if (fracao == FRAC_ULT) begin
                    fracao_prox     = '0;
                    andar_base_prox = andar_base + 3'd1;
                end else begin
                    fracao_prox = fracao + FRAC_W'(1);
                end
            end
            PASSO_DESCE: begin
                posicao_prox = posicao - POS_W'(1);
                if (fracao == '0) begin
                    fracao_prox     = FRAC_ULT;
                    andar_base_prox = andar_base - 3'd1;
                end else begin
                    fracao_prox = fracao - FRAC_W'(1);
                end
            end
            default: begin
            end
        endcase

        if (!motor_liga) begin
            em_movimento_prox = 1'b0;
        end else if (passo == PASSO_SOBE || passo == PASSO_DESCE) begin
            em_movimento_prox = 1'b1;
        end else if (passo == PASSO_BLOQUEADO) begin
            em_movimento_prox = 1'b0;
        end

        // Between levels the last level reached is held, whichever way the cabin moves.
        andar_prox = (fracao_prox == '0) ? andar_base_prox : andar_atual;
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values and the update order inside the block does not matter.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler     <= '0;
            fracao        <= '0;
            andar_base    <= ANDAR_INI;
            posicao       <= POS_INI;
            andar_atual   <= ANDAR_INI;
            no_nivel      <= 1'b1;
            em_movimento  <= 1'b0;
            fim_curso_inf <= (POS_INI == '0);
            fim_curso_sup <= (POS_INI == POS_MAX);
            falha         <= 1'b0;
        end else begin
            prescaler     <= prescaler_prox;
            fracao        <= fracao_prox;
            andar_base    <= andar_base_prox;
            posicao       <= posicao_prox;
            andar_atual   <= andar_prox;
            no_nivel      <= (fracao_prox == '0);
            em_movimento  <= em_movimento_prox;
            fim_curso_inf <= (posicao_prox == '0);
            fim_curso_sup <= (posicao_prox == POS_MAX);
            falha         <= falha || (passo == PASSO_BLOQUEADO);
        end
    end

endmodule

// File: tb/tb_sensor_andar_cabine.sv
// Self-checking bench for sensor_andar_cabine: vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_sensor_andar_cabine;

    localparam int N     = 5;
    localparam int T     = 4;
    localparam int D     = 2;
    localparam int PMAX  = (N - 1) * T;
    localparam int POS_W = 8;

    logic             clock = 1'b0;
    logic             reset, motor_liga, motor_direcao;
    logic [2:0]       andar_atual;
    logic [POS_W-1:0] posicao;
    logic             no_nivel, em_movimento, fim_curso_inf, fim_curso_sup, falha;

    logic             reset2, motor_liga2, motor_direcao2;
    logic [2:0]       andar_atual2;
    logic [POS_W-1:0] posicao2;
    logic             no_nivel2, em_movimento2, fim_curso_inf2, fim_curso_sup2, falha2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state for the default instance
    int m_pos, m_presc, m_andar;
    bit m_em, m_falha;

    always #5 clock = ~clock;

    sensor_andar_cabine #(
        .N_ANDARES(N), .TICKS_POR_ANDAR(T), .DIVISOR(D), .ANDAR_INICIAL(0), .POS_W(POS_W)
    ) dut (
        .clock(clock), .reset(reset), .motor_liga(motor_liga), .motor_direcao(motor_direcao),
        .andar_atual(andar_atual), .posicao(posicao), .no_nivel(no_nivel),
        .em_movimento(em_movimento), .fim_curso_inf(fim_curso_inf),
        .fim_curso_sup(fim_curso_sup), .falha(falha)
    );

    sensor_andar_cabine #(
        .N_ANDARES(N), .TICKS_POR_ANDAR(T), .DIVISOR(D), .ANDAR_INICIAL(2), .POS_W(POS_W)
    ) dut2 (
        .clock(clock), .reset(reset2), .motor_liga(motor_liga2), .motor_direcao(motor_direcao2),
        .andar_atual(andar_atual2), .posicao(posicao2), .no_nivel(no_nivel2),
        .em_movimento(em_movimento2), .fim_curso_inf(fim_curso_inf2),
        .fim_curso_sup(fim_curso_sup2), .falha(falha2)
    );

    typedef struct {
        bit rst;
        bit liga;
        bit dir;
        int pos;
        int andar;
        bit nivel;
        bit em;
        bit falha;
    } vetor_t;

    vetor_t tab[14];

    task automatic check(input string nome, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, actual, expected, $time);
        end
    endtask

    // Spec rules in plain arithmetic: prescaler counts motor-on cycles, a step
    // every D-th one, saturation at 0/PMAX raises the fault.
    task automatic model_update(input bit rst, input bit liga, input bit dir);
        bit opp, moved, blocked;
        if (rst) begin
            m_pos = 0; m_presc = 0; m_andar = 0; m_em = 0; m_falha = 0;
            return;
        end
        opp     = liga && (m_presc == D - 1);
        moved   = 0;
        blocked = 0;
        if (!liga || opp) m_presc = 0;
        else              m_presc = m_presc + 1;
        if (opp) begin
            if (dir) begin
                if (m_pos < PMAX) begin m_pos = m_pos + 1; moved = 1; end
                else blocked = 1;
            end else begin
                if (m_pos > 0) begin m_pos = m_pos - 1; moved = 1; end
                else blocked = 1;
            end
        end
        if (blocked) m_falha = 1;
        if (!liga)        m_em = 0;
        else if (moved)   m_em = 1;
        else if (blocked) m_em = 0;
        if (m_pos % T == 0) m_andar = m_pos / T;
    endtask

    task automatic step(input bit rst, input bit liga, input bit dir);
        reset         = rst;
        motor_liga    = liga;
        motor_direcao = dir;
        @(posedge clock);
        model_update(rst, liga, dir);
        #1;
    endtask

    task automatic step2(input bit rst, input bit liga, input bit dir);
        reset2         = rst;
        motor_liga2    = liga;
        motor_direcao2 = dir;
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " posicao"},       int'(posicao),       m_pos);
        check({tag, " andar_atual"},   int'(andar_atual),   m_andar);
        check({tag, " no_nivel"},      int'(no_nivel),      int'(m_pos % T == 0));
        check({tag, " em_movimento"},  int'(em_movimento),  int'(m_em));
        check({tag, " fim_curso_inf"}, int'(fim_curso_inf), int'(m_pos == 0));
        check({tag, " fim_curso_sup"}, int'(fim_curso_sup), int'(m_pos == PMAX));
        check({tag, " falha"},         int'(falha),         int'(m_falha));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dir_r, liga_r, rst_r;

        reset = 1'b1; motor_liga = 1'b0; motor_direcao = 1'b0;
        reset2 = 1'b1; motor_liga2 = 1'b0; motor_direcao2 = 1'b0;

        //              rst liga dir pos andar nivel em falha
        tab[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
        tab[2]  = '{1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0};
        tab[3]  = '{1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0};
        tab[4]  = '{1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0};
        tab[6]  = '{1'b0, 1'b1, 1'b1, 3, 0, 1'b0, 1'b1, 1'b0};
        tab[7]  = '{1'b0, 1'b1, 1'b1, 3, 0, 1'b0, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 1'b1, 1'b1, 4, 1, 1'b1, 1'b1, 1'b0};
        tab[9]  = '{1'b0, 1'b0, 1'b1, 4, 1, 1'b1, 1'b0, 1'b0};
        tab[10] = '{1'b0, 1'b1, 1'b1, 4, 1, 1'b1, 1'b0, 1'b0};
        tab[11] = '{1'b0, 1'b0, 1'b1, 4, 1, 1'b1, 1'b0, 1'b0};
        tab[12] = '{1'b0, 1'b1, 1'b1, 4, 1, 1'b1, 1'b0, 1'b0};
        tab[13] = '{1'b0, 1'b1, 1'b1, 5, 1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(tab[i].rst, tab[i].liga, tab[i].dir);
            check($sformatf("tab[%0d] posicao", i),       int'(posicao),       tab[i].pos);
            check($sformatf("tab[%0d] andar_atual", i),   int'(andar_atual),   tab[i].andar);
            check($sformatf("tab[%0d] no_nivel", i),      int'(no_nivel),      int'(tab[i].nivel));
            check($sformatf("tab[%0d] em_movimento", i),  int'(em_movimento),  int'(tab[i].em));
            check($sformatf("tab[%0d] falha", i),         int'(falha),         int'(tab[i].falha));
            check($sformatf("tab[%0d] fim_curso_inf", i), int'(fim_curso_inf), int'(tab[i].pos == 0));
            check($sformatf("tab[%0d] fim_curso_sup", i), int'(fim_curso_sup), int'(tab[i].pos == PMAX));
        end

        // Reversal between levels: 5 -> 6, then back down to 4
        repeat (2) begin step(0, 1, 1); check_model("rev up"); end
        check("rev peak posicao", int'(posicao), 6);
        repeat (4) begin step(0, 1, 0); check_model("rev down"); end
        check("rev posicao", int'(posicao), 4);
        check("rev andar_atual", int'(andar_atual), 1);
        check("rev no_nivel", int'(no_nivel), 1);

        // Lower limit: travel to 0, then drive down into it
        repeat (8) begin step(0, 1, 0); check_model("to bottom"); end
        check("bottom posicao", int'(posicao), 0);
        step(0, 1, 0);
        check("bottom pre-block falha", int'(falha), 0);
        step(0, 1, 0);
        check("bottom block falha", int'(falha), 1);
        check("bottom block posicao", int'(posicao), 0);
        check("bottom block em_movimento", int'(em_movimento), 0);
        repeat (2) begin step(0, 1, 0); check_model("bottom hold"); end
        repeat (2) begin step(0, 0, 0); check_model("bottom idle"); end
        check("bottom sticky falha", int'(falha), 1);
        step(1, 0, 0);
        check("bottom reset falha", int'(falha), 0);

        // Upper limit
        repeat (32) begin step(0, 1, 1); check_model("to top"); end
        check("top posicao", int'(posicao), PMAX);
        check("top andar_atual", int'(andar_atual), N - 1);
        check("top fim_curso_sup", int'(fim_curso_sup), 1);
        repeat (2) begin step(0, 1, 1); check_model("top block"); end
        check("top falha", int'(falha), 1);
        check("top block posicao", int'(posicao), PMAX);
        step(1, 0, 0);
        check_model("top reset");

        // Reset while moving at posicao 10
        repeat (20) begin step(0, 1, 1); check_model("to 10"); end
        check("mid posicao", int'(posicao), 10);
        step(1, 1, 1);
        check("mid reset posicao", int'(posicao), 0);
        check("mid reset andar_atual", int'(andar_atual), 0);
        check("mid reset em_movimento", int'(em_movimento), 0);
        step(0, 1, 1);
        check("post reset 1st cycle posicao", int'(posicao), 0);
        step(0, 1, 1);
        check("post reset 2nd cycle posicao", int'(posicao), 1);
        check("post reset em_movimento", int'(em_movimento), 1);

        // Randomized traffic with sticky direction for long runs
        dir_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rst_r  = ($urandom_range(0, 199) == 0);
            liga_r = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 11) == 0) dir_r = ~dir_r;
            step(rst_r, liga_r, dir_r);
            check_model($sformatf("rnd[%0d]", i));
        end
        step(1, 0, 0);

        // Preloaded instance: ANDAR_INICIAL = 2
        step2(1, 0, 0);
        check("pre reset posicao", int'(posicao2), 8);
        check("pre reset andar_atual", int'(andar_atual2), 2);
        check("pre reset no_nivel", int'(no_nivel2), 1);
        check("pre reset fim_curso_inf", int'(fim_curso_inf2), 0);
        check("pre reset fim_curso_sup", int'(fim_curso_sup2), 0);
        repeat (2) step2(0, 1, 0);
        check("pre 2cyc posicao", int'(posicao2), 7);
        check("pre 2cyc andar_atual", int'(andar_atual2), 2);
        check("pre 2cyc no_nivel", int'(no_nivel2), 0);
        repeat (6) step2(0, 1, 0);
        check("pre 8cyc posicao", int'(posicao2), 4);
        check("pre 8cyc andar_atual", int'(andar_atual2), 1);
        check("pre 8cyc no_nivel", int'(no_nivel2), 1);
        repeat (2) step2(0, 1, 0);
        step2(0, 0, 0);
        check("overtravel posicao", int'(posicao2), 3);
        check("overtravel andar_atual", int'(andar_atual2), 1);
        check("overtravel no_nivel", int'(no_nivel2), 0);
        check("overtravel em_movimento", int'(em_movimento2), 0);
        check("overtravel falha", int'(falha2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
